axi_rd_slave: RTL and testbench

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

---
 rtl/axi_rd_pkg.sv | 31 +++
 rtl/axi_rd_addr_gen.sv | 31 +++
 rtl/axi_rd_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_rd_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared widths, response codes and enums for the AXI read slave.
// Pulled into every file of the block with import axi_rd_pkg::*.
package axi_rd_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int LENGTH     = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rstate_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// WRAP keeps the low bits inside a (len+1)<<size byte aligned window.
module axi_rd_addr_gen
    import axi_rd_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [LENGTH-1:0]     len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign step      = ADDR_WIDTH'(1) << size;
    assign incr      = addr + step;
    assign wrap_mask = ((ADDR_WIDTH'(len) + 32'd1) << size) - 32'd1;

    always_comb begin
        next_addr = incr;
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask)
                                   | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read slave fronting a synchronous word memory, one burst at a time.
// Define AXI_RD_WRAP_EN to accept WRAP bursts; otherwise they return SLVERR.
module axi_rd_slave
    import axi_rd_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              Aclock,
    input  logic              Areset,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    rstate_e               state, state_nxt;
    logic                  alive;
    logic [3:0]            id_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [LENGTH-1:0]     len_q;
    logic [2:0]            size_q;
    burst_e                burst_q;
    logic [LENGTH:0]       issued_q;

    logic                  infl_vld;
    logic [1:0]            infl_resp;
    logic                  infl_last;

    beat_t                 fifo_q [2];
    beat_t                 head, push_beat;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    logic                  ar_hs, r_hs, issue;
    logic                  burst_err, dec_err, beat_last;
    logic [1:0]            beat_resp;
    logic [2:0]            occ;
    logic                  unused_bits;

    assign arready = alive && (state == R_IDLE);
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;

    assign head   = fifo_q[rd_ptr];
    assign rvalid = (count != 2'd0);
    assign rdata  = head.data;
    assign rresp  = head.resp;
    assign rlast  = rvalid && head.last;
    assign rid    = id_q;

    always_comb begin
        burst_err = 1'b1;
        unique case (burst_q)
            BURST_FIXED, BURST_INCR:
                burst_err = (size_q > 3'd2);
`ifdef AXI_RD_WRAP_EN
            BURST_WRAP:
                burst_err = (size_q > 3'd2)
                    || !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
            BURST_WRAP:
                burst_err = 1'b1;
`endif
            default:
                burst_err = 1'b1;
        endcase
    end

    assign dec_err   = |addr_q[ADDR_WIDTH-1:MEM_AW+2];
    assign beat_resp = burst_err ? RESP_SLVERR
                     : dec_err   ? RESP_DECERR
                     :             RESP_OKAY;
    assign beat_last = (issued_q == {1'b0, len_q});

    // Slots freed by this cycle's pop may be refilled immediately.
    assign occ   = {1'b0, count} + {2'b00, infl_vld} - {2'b00, r_hs};
    assign issue = (state == R_BURST)
                && (issued_q <= {1'b0, len_q})
                && (occ < 3'd2);

    assign mem_rd_en   = issue && (beat_resp == RESP_OKAY);
    assign mem_addr    = addr_q[MEM_AW+1:2];
    assign unused_bits = ^addr_q[1:0];

    assign push_beat = {
        (infl_resp == RESP_OKAY) ? mem_rdata : 32'd0,
        infl_resp,
        infl_last
    };

    axi_rd_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            R_IDLE:  if (ar_hs) state_nxt = R_BURST;
            R_BURST: if (r_hs && rlast) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge Aclock or posedge Areset) begin
        if (Areset) begin
            state <= R_IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
        end
    end

    always_ff @(posedge Aclock or posedge Areset) begin
        if (Areset) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BURST_FIXED;
            issued_q <= '0;
        end else if (ar_hs) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= burst_e'(arburst);
            issued_q <= '0;
        end else if (issue) begin
            addr_q   <= addr_nxt;
            issued_q <= issued_q + 1'b1;
        end
    end

    // Every beat, error or not, spends one cycle in flight.
    always_ff @(posedge Aclock or posedge Areset) begin
        if (Areset) begin
            infl_vld  <= 1'b0;
            infl_resp <= RESP_OKAY;
            infl_last <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
        end else begin
            infl_vld  <= issue;
            infl_resp <= beat_resp;
            infl_last <= beat_last;
            if (infl_vld) begin
                fifo_q[wr_ptr] <= push_beat;
                wr_ptr         <= ~wr_ptr;
            end
            if (r_hs) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, infl_vld} - {1'b0, r_hs};
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: vector table, random bursts and a mid-burst reset.
// Beats are scored against an address/response model built from burst rules.
module tb_axi_rd_slave;

    logic        Aclock;
    logic        Areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    axi_rd_slave #(.MEM_AW(10)) dut (
        .Aclock    (Aclock),
        .Areset    (Areset),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          mode;
        bit          chk0;
        logic [31:0] d0;
        logic [1:0]  r0;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic [31:0] mem [1024];
    exp_t        exp_q [$];
    vec_t        tab [11];
    int          checks;
    int          errors;
    int          rd_cnt;

    initial Aclock = 1'b0;
    always #5 Aclock = ~Aclock;

    always @(posedge Aclock)
        if (mem_rd_en) mem_rdata <= mem[mem_addr];

    always @(negedge Aclock)
        if (mem_rd_en) rd_cnt = rd_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats from the burst rules with plain 64-bit arithmetic.
    task automatic build_exp(input vec_t v);
        longint unsigned sz, w, st, base, a;
        bit err;
        exp_q.delete();
        sz   = 64'd1 << v.size;
        st   = 64'(v.addr);
        w    = (64'(v.len) + 1) * sz;
        base = st - (st % w);
        err  = (v.size > 3'd2) || (v.burst == 2'b11);
        if (v.burst == 2'b10) begin
`ifdef AXI_RD_WRAP_EN
            if (!(v.len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
`else
            err = 1'b1;
`endif
        end
        for (int i = 0; i <= int'(v.len); i++) begin
            case (v.burst)
                2'b00:   a = st;
                2'b10:   a = base + ((st - base + 64'(i) * sz) % w);
                default: a = (st + 64'(i) * sz) % (64'd1 << 32);
            endcase
            if (err)
                exp_q.push_back('{32'h0, 2'b10});
            else if (a >= 64'd4096)
                exp_q.push_back('{32'h0, 2'b11});
            else
                exp_q.push_back('{32'(a / 4) * 32'h01010101, 2'b00});
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_burst(input vec_t v, input string tag);
        int   lat, idx, first_lat, last_lat, rd0, wc, n_ok;
        bit   done, held;
        logic [39:0] h;
        build_exp(v);
        n_ok = 0;
        foreach (exp_q[k]) if (exp_q[k].resp == 2'b00) n_ok++;
        arid    = v.id;
        araddr  = v.addr;
        arlen   = v.len;
        arsize  = v.size;
        arburst = v.burst;
        arvalid = 1'b1;
        rready  = 1'b0;
        wc = 0;
        while (arready !== 1'b1 && wc < 50) begin
            @(posedge Aclock); #1;
            wc++;
        end
        if (arready !== 1'b1) begin
            check({tag, " arready wait"}, 64'(arready), 64'd1);
            arvalid = 1'b0;
            return;
        end
        rd0 = rd_cnt;
        @(posedge Aclock); #1;
        arvalid   = 1'b0;
        lat       = 0;
        idx       = 0;
        done      = 0;
        held      = 0;
        first_lat = -1;
        last_lat  = 0;
        h         = '0;
        while (!done && lat < 1000) begin
            case (v.mode)
                0:       rready = 1'b1;
                1:       rready = (lat % 2) == 1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (held)
                check({tag, " stall stable"},
                      64'({rvalid, rlast, rid, rresp, rdata}), 64'(h));
            held = 0;
            if (rvalid) begin
                if (first_lat < 0) first_lat = lat;
                if (rready) begin
                    if (idx < exp_q.size()) begin
                        check($sformatf("%s beat%0d", tag, idx),
                              64'({rid, rresp, rlast, rdata}),
                              64'({v.id, exp_q[idx].resp,
                                   idx == int'(v.len),
                                   exp_q[idx].data}));
                        if (idx == 0 && v.chk0)
                            check({tag, " first beat"},
                                  64'({rresp, rdata}), 64'({v.r0, v.d0}));
                    end else begin
                        check({tag, " extra beat"}, 64'(idx),
                              64'(exp_q.size()));
                    end
                    idx++;
                    last_lat = lat;
                    if (rlast) done = 1;
                end else begin
                    held = 1;
                    h = {rvalid, rlast, rid, rresp, rdata};
                end
            end
            @(posedge Aclock); #1;
            lat++;
        end
        rready = 1'b0;
        check({tag, " completed"}, 64'(done), 64'd1);
        check({tag, " beat count"}, 64'(idx), 64'(int'(v.len) + 1));
        check({tag, " first latency"}, 64'(first_lat), 64'd2);
        if (v.mode == 0)
            check({tag, " throughput"}, 64'(last_lat - first_lat),
                  64'(v.len));
        check({tag, " arready after rlast"}, 64'(arready), 64'd1);
        check({tag, " mem reads"}, 64'(rd_cnt - rd0), 64'(n_ok));
    endtask

    initial begin
        vec_t v;
        int   wc;
        checks = 0;
        errors = 0;
        rd_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h01010101;

        tab[0]  = '{4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 0, 1'b1,
                    32'h04040404, 2'b00};
        tab[1]  = '{4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 1, 1'b1,
                    32'h04040404, 2'b00};
        tab[2]  = '{4'd2, 32'h8, 8'd2, 3'd2, 2'b00, 0, 1'b1,
                    32'h02020202, 2'b00};
        tab[3]  = '{4'd3, 32'h0001_0000, 8'd1, 3'd2, 2'b01, 0, 1'b1,
                    32'h0, 2'b11};
`ifdef AXI_RD_WRAP_EN
        tab[4]  = '{4'd7, 32'h18, 8'd3, 3'd2, 2'b10, 0, 1'b1,
                    32'h06060606, 2'b00};
`else
        tab[4]  = '{4'd7, 32'h18, 8'd3, 3'd2, 2'b10, 0, 1'b1,
                    32'h0, 2'b10};
`endif
        tab[5]  = '{4'd1, 32'h0, 8'd0, 3'd3, 2'b01, 0, 1'b1,
                    32'h0, 2'b10};
        tab[6]  = '{4'd9, 32'h20, 8'd1, 3'd2, 2'b11, 1, 1'b1,
                    32'h0, 2'b10};
        tab[7]  = '{4'd4, 32'hFFC, 8'd2, 3'd2, 2'b01, 0, 1'b1,
                    32'h030302FF, 2'b00};
        tab[8]  = '{4'd15, 32'h44, 8'd0, 3'd2, 2'b01, 0, 1'b1,
                    32'h11111111, 2'b00};
        tab[9]  = '{4'd8, 32'h2, 8'd3, 3'd1, 2'b01, 2, 1'b1,
                    32'h0, 2'b00};
        tab[10] = '{4'd6, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, 0, 1'b1,
                    32'h0, 2'b11};

        Areset  = 1'b1;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        #1;
        check("reset arready", 64'(arready), 64'd0);
        check("reset outputs",
              64'({rvalid, rlast, mem_rd_en, rid, rresp}), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        @(posedge Aclock); @(posedge Aclock); #1;
        Areset = 1'b0;
        check("arready before edge", 64'(arready), 64'd0);
        @(posedge Aclock); #1;
        check("arready after release", 64'(arready), 64'd1);

        for (int i = 0; i < 11; i++)
            run_burst(tab[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            v.id    = 4'($urandom_range(0, 15));
            v.size  = 3'($urandom_range(0, 3));
            v.burst = 2'($urandom_range(0, 3));
            v.len   = 8'($urandom_range(0, 12));
            if (v.burst == 2'b10 && $urandom_range(0, 3) != 0)
                v.len = 8'((1 << $urandom_range(1, 4)) - 1);
            if ($urandom_range(0, 9) == 0)
                v.addr = $urandom;
            else
                v.addr = 32'($urandom_range(0, 4095));
            if (v.size <= 3'd2)
                v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
            v.mode = $urandom_range(0, 2);
            v.chk0 = 1'b0;
            v.d0   = '0;
            v.r0   = '0;
            run_burst(v, $sformatf("rnd%0d", i));
        end

        // Reset after the first beat of a long INCR burst.
        arid    = 4'd6;
        araddr  = 32'h0;
        arlen   = 8'd7;
        arsize  = 3'd2;
        arburst = 2'b01;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(posedge Aclock); #1;
        arvalid = 1'b0;
        wc = 0;
        while (rvalid !== 1'b1 && wc < 20) begin
            @(posedge Aclock); #1;
            wc++;
        end
        check("rst burst beat0 data", 64'(rdata), 64'd0);
        @(posedge Aclock); #1;
        check("rst burst pre-reset rvalid", 64'(rvalid), 64'd1);
        Areset = 1'b1;
        #1;
        check("mid reset rvalid", 64'(rvalid), 64'd0);
        check("mid reset ctrl",
              64'({arready, rlast, mem_rd_en, rid, rresp}), 64'd0);
        check("mid reset rdata", 64'(rdata), 64'd0);
        @(posedge Aclock); #1;
        Areset = 1'b0;
        rready = 1'b0;
        check("arready held low", 64'(arready), 64'd0);
        @(posedge Aclock); #1;
        check("arready first edge", 64'(arready), 64'd1);
        run_burst(tab[0], "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
